// File: rtl/rob_pkg.sv
// rob_pkg: shared definitions for the reorder-buffer pointer controller.
//   ROB_SIZE    - default number of ROB entries (power of 2)
//   rob_idx_t   - entry index for the default-size ROB
//   rob_cnt_t   - occupancy value for the default-size ROB (0..ROB_SIZE)
//   rob_dist()  - modulo distance from a to b in a ring of 'size' entries
package rob_pkg;

  localparam int ROB_SIZE   = 16;
  localparam int ROB_ADDR_W = $clog2(ROB_SIZE);

  typedef logic [ROB_ADDR_W-1:0] rob_idx_t;
  typedef logic [ROB_ADDR_W:0]   rob_cnt_t;

  // Number of steps from a forward to b; size must be a power of 2.
  function automatic int unsigned rob_dist(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned size);
    return (b - a) & (size - 1);
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl_if.sv
// rob_ptr_ctrl_if: allocation / retire / squash bundle of the ROB pointer
// controller.
//   master modport: rename/dispatch + commit side (drives requests)
//   slave  modport: the controller (drives indices, status and occupancy)
//   alloc_cnt_i / retire_cnt_i - requested allocations / retirements
//   flush_i                    - squash every entry
//   rollback_i, rollback_tail_i- partial squash (only with ROB_ROLLBACK_EN)
//   alloc_idx_o                - slot k = (tail + k) mod ROBsize
//   alloc_ok_o / stall_o       - request accepted / refused for space
//   head_o, tail_o, count_o, free_o, full_o, empty_o - registered state
// Optional feature macro: ROB_ROLLBACK_EN.
interface rob_ptr_ctrl_if #(
  parameter int ROBsize  = 16,
  parameter int ALLOC_W  = 2,
  parameter int RETIRE_W = 2
);
  localparam int addrSize = $clog2(ROBsize);

  logic [$clog2(ALLOC_W+1)-1:0]      alloc_cnt_i;
  logic [$clog2(RETIRE_W+1)-1:0]     retire_cnt_i;
  logic                              flush_i;
`ifdef ROB_ROLLBACK_EN
  logic                              rollback_i;
  logic [addrSize-1:0]               rollback_tail_i;
`endif
  logic [ALLOC_W-1:0][addrSize-1:0]  alloc_idx_o;
  logic                              alloc_ok_o;
  logic                              stall_o;
  logic [addrSize-1:0]               head_o;
  logic [addrSize-1:0]               tail_o;
  logic [addrSize:0]                 count_o;
  logic [addrSize:0]                 free_o;
  logic                              full_o;
  logic                              empty_o;

  modport master (
`ifdef ROB_ROLLBACK_EN
    output rollback_i, rollback_tail_i,
`endif
    output alloc_cnt_i, retire_cnt_i, flush_i,
    input  alloc_idx_o, alloc_ok_o, stall_o, head_o, tail_o,
           count_o, free_o, full_o, empty_o
  );

  modport slave (
`ifdef ROB_ROLLBACK_EN
    input  rollback_i, rollback_tail_i,
`endif
    input  alloc_cnt_i, retire_cnt_i, flush_i,
    output alloc_idx_o, alloc_ok_o, stall_o, head_o, tail_o,
           count_o, free_o, full_o, empty_o
  );

endinterface

// File: rtl/rob_ptr_adv.sv
// rob_ptr_adv: wrapping ring pointer plus count adder.
//   ptr_i - current index (AW bits)
//   add_i - step count (CW bits)
//   ptr_o - (ptr_i + add_i) mod 2**AW
// The ring size is a power of 2, so dropping the carry is the wrap.
module rob_ptr_adv #(
  parameter int AW = 4,
  parameter int CW = 5
) (
  input  logic [AW-1:0] ptr_i,
  input  logic [CW-1:0] add_i,
  output logic [AW-1:0] ptr_o
);
  localparam int SW = (AW > CW) ? AW : CW;

  assign ptr_o = AW'(SW'(ptr_i) + SW'(add_i));

endmodule

// File: rtl/rob_ptr_ctrl.sv
// rob_ptr_ctrl: head/tail pointer and exact-occupancy controller for the
// reorder buffer. Allocates up to ALLOC_W consecutive entries at the tail
// (all-or-nothing) and retires up to RETIRE_W entries at the head per cycle.
//   clk_i    - clock, rising edge
//   reset_ni - asynchronous active-low reset
//   bus      - rob_ptr_ctrl_if.slave (requests in, indices/status out)
// Optional feature macro: ROB_ROLLBACK_EN (tail rollback on mispredict).
module rob_ptr_ctrl
  import rob_pkg::*;
#(
  parameter int ROBsize  = ROB_SIZE,
  parameter int ALLOC_W  = 2,
  parameter int RETIRE_W = 2
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  rob_ptr_ctrl_if.slave bus
);
  localparam int addrSize = $clog2(ROBsize);
  localparam int CNT_W    = addrSize + 1;

  logic [addrSize-1:0] head_reg, head_next;
  logic [addrSize-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0]    count_reg, count_next;

  logic [CNT_W-1:0]    free_cnt;
  logic [CNT_W-1:0]    alloc_req;
  logic [CNT_W-1:0]    alloc_eff;
  logic [CNT_W-1:0]    alloc_acc;
  logic [CNT_W-1:0]    ret_req;
  logic [CNT_W-1:0]    ret_eff;
  logic                stall;
  logic                alloc_ok;
  logic                squash;
  logic [CNT_W-1:0]    rb_count;
  logic [addrSize-1:0] rb_tail;
  logic [addrSize-1:0] head_adv;
  logic [addrSize-1:0] tail_adv;
  logic [ALLOC_W-1:0][addrSize-1:0] alloc_idx;

  // Out-of-range requests saturate at the per-cycle width.
  assign alloc_req = CNT_W'(bus.alloc_cnt_i);
  assign ret_req   = CNT_W'(bus.retire_cnt_i);
  assign alloc_eff = (alloc_req > CNT_W'(ALLOC_W))  ? CNT_W'(ALLOC_W)  : alloc_req;

  // Space comes only from the current count; same-cycle retirements are
  // not credited, which keeps the stall path off the retire path.
  assign free_cnt  = CNT_W'(ROBsize) - count_reg;

  // Retiring more than is held is clamped silently.
  always_comb begin
    ret_eff = (ret_req > CNT_W'(RETIRE_W)) ? CNT_W'(RETIRE_W) : ret_req;
    if (ret_eff > count_reg) begin
      ret_eff = count_reg;
    end
  end

`ifdef ROB_ROLLBACK_EN
  // A rollback to the current tail squashes nothing and is ignored.
  logic [CNT_W-1:0] rb_dist;
  assign rb_tail  = bus.rollback_tail_i;
  assign squash   = bus.rollback_i && (bus.rollback_tail_i != tail_reg);
  assign rb_dist  = CNT_W'(rob_dist(32'(head_reg), 32'(bus.rollback_tail_i), ROBsize));
  assign rb_count = (rb_dist > ret_eff) ? (rb_dist - ret_eff) : '0;
`else
  assign rb_tail  = tail_reg;
  assign squash   = 1'b0;
  assign rb_count = count_reg;
`endif

  assign stall     = (alloc_eff > free_cnt) && !bus.flush_i;
  assign alloc_ok  = (alloc_eff != '0) && !stall && !bus.flush_i && !squash;
  assign alloc_acc = alloc_ok ? alloc_eff : '0;

  rob_ptr_adv #(.AW(addrSize), .CW(CNT_W)) u_head_adv (
    .ptr_i (head_reg),
    .add_i (ret_eff),
    .ptr_o (head_adv)
  );

  rob_ptr_adv #(.AW(addrSize), .CW(CNT_W)) u_tail_adv (
    .ptr_i (tail_reg),
    .add_i (alloc_acc),
    .ptr_o (tail_adv)
  );

  // Allocation slots are presented combinationally in the request cycle.
  generate
    for (genvar gi = 0; gi < ALLOC_W; gi++) begin : g_slot
      rob_ptr_adv #(.AW(addrSize), .CW(CNT_W)) u_slot_adv (
        .ptr_i (tail_reg),
        .add_i (CNT_W'(gi)),
        .ptr_o (alloc_idx[gi])
      );
    end
  endgenerate

  // Flush beats rollback, which beats ordinary alloc/retire.
  always_comb begin
    head_next  = head_adv;
    tail_next  = tail_adv;
    count_next = count_reg + alloc_acc - ret_eff;
    if (bus.flush_i) begin
      head_next  = head_reg;
      tail_next  = head_reg;
      count_next = '0;
    end else if (squash) begin
      tail_next  = rb_tail;
      count_next = rb_count;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign bus.alloc_idx_o = alloc_idx;
  assign bus.alloc_ok_o  = alloc_ok;
  assign bus.stall_o     = stall;
  assign bus.head_o      = head_reg;
  assign bus.tail_o      = tail_reg;
  assign bus.count_o     = count_reg;
  assign bus.free_o      = free_cnt;
  assign bus.full_o      = (count_reg == CNT_W'(ROBsize));
  assign bus.empty_o     = (count_reg == '0);

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// tb_rob_ptr_ctrl: directed bench for rob_ptr_ctrl with ROBsize=8,
// ALLOC_W=2, RETIRE_W=2. Rollback steps are built only with ROB_ROLLBACK_EN.
module tb_rob_ptr_ctrl;
  localparam int RS = 8;
  localparam int AW = 2;
  localparam int RW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_ptr_ctrl_if #(.ROBsize(RS), .ALLOC_W(AW), .RETIRE_W(RW)) bus ();

  rob_ptr_ctrl #(.ROBsize(RS), .ALLOC_W(AW), .RETIRE_W(RW)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a, input int r, input bit f);
    bus.alloc_cnt_i  = 2'(a);
    bus.retire_cnt_i = 2'(r);
    bus.flush_i      = f;
`ifdef ROB_ROLLBACK_EN
    bus.rollback_i      = 1'b0;
    bus.rollback_tail_i = '0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic state(input string tag, input int h, input int t, input int c);
    check({tag, ".head"},  32'(bus.head_o),  32'(h));
    check({tag, ".tail"},  32'(bus.tail_o),  32'(t));
    check({tag, ".count"}, 32'(bus.count_o), 32'(c));
    check({tag, ".free"},  32'(bus.free_o),  32'(RS - c));
    check({tag, ".full"},  32'(bus.full_o),  32'(c == RS));
    check({tag, ".empty"}, 32'(bus.empty_o), 32'(c == 0));
    $display("step %-10s head=%0d tail=%0d count=%0d", tag, bus.head_o, bus.tail_o, bus.count_o);
  endtask

  task automatic alloc_chk(input string tag, input int ok, input int st);
    check({tag, ".ok"},    32'(bus.alloc_ok_o), 32'(ok));
    check({tag, ".stall"}, 32'(bus.stall_o),    32'(st));
  endtask

  initial begin
    drive(0, 0, 1'b0);
    #1;
    state("reset", 0, 0, 0);
    alloc_chk("reset", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill: two per cycle, indices {0,1},{2,3},{4,5},{6,7}
    for (int i = 0; i < 4; i++) begin
      drive(2, 0, 1'b0);
      #1;
      check("fill.idx0", 32'(bus.alloc_idx_o[0]), 32'(2 * i));
      check("fill.idx1", 32'(bus.alloc_idx_o[1]), 32'(2 * i + 1));
      alloc_chk("fill", 1, 0);
      tick();
    end
    state("full", 0, 0, 8);
    drive(1, 0, 1'b0);
    #1;
    alloc_chk("full_req", 0, 1);
    tick();
    state("full_hold", 0, 0, 8);

    // All-or-nothing at count=7
    drive(0, 1, 1'b0); tick();
    state("cnt7", 1, 0, 7);
    drive(2, 0, 1'b0);
    #1;
    alloc_chk("aon2", 0, 1);
    tick();
    state("aon2", 1, 0, 7);
    drive(1, 0, 1'b0);
    #1;
    alloc_chk("aon1", 1, 0);
    check("aon1.idx0", 32'(bus.alloc_idx_o[0]), 32'd0);
    tick();
    state("aon1", 1, 1, 8);

    // Reach head=6, tail=2, count=4 then wrap with simultaneous events
    drive(0, 2, 1'b0); tick();
    drive(0, 2, 1'b0); tick();
    drive(0, 1, 1'b0); tick();
    drive(1, 0, 1'b0); tick();
    state("pre_wrap", 6, 2, 4);
    drive(2, 2, 1'b0);
    #1;
    check("wrap.idx0", 32'(bus.alloc_idx_o[0]), 32'd2);
    check("wrap.idx1", 32'(bus.alloc_idx_o[1]), 32'd3);
    alloc_chk("wrap", 1, 0);
    tick();
    state("wrap", 0, 4, 4);

    // Drain to count=1, then over-retire
    drive(0, 2, 1'b0); tick();
    drive(0, 1, 1'b0); tick();
    state("cnt1", 3, 4, 1);
    drive(0, 2, 1'b0); tick();
    state("over_ret", 4, 4, 0);
    drive(0, 2, 1'b0); tick();
    state("empty_ret", 4, 4, 0);

    // Allocate 5 (first request out of range, saturates to 2)
    drive(3, 0, 1'b0);
    #1;
    check("sat.idx0", 32'(bus.alloc_idx_o[0]), 32'd4);
    check("sat.idx1", 32'(bus.alloc_idx_o[1]), 32'd5);
    alloc_chk("sat", 1, 0);
    tick();
    state("sat", 4, 6, 2);
    drive(2, 0, 1'b0); tick();
    drive(1, 0, 1'b0); tick();
    state("alloc5", 4, 1, 5);

    // Asynchronous reset in the middle of a cycle
    drive(0, 0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    state("async_rst", 0, 0, 0);
    alloc_chk("async_rst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // First allocation after reset gets index 0 immediately
    drive(2, 0, 1'b0);
    #1;
    check("first.idx0", 32'(bus.alloc_idx_o[0]), 32'd0);
    check("first.idx1", 32'(bus.alloc_idx_o[1]), 32'd1);
    alloc_chk("first", 1, 0);
    tick();
    state("first", 0, 2, 2);

    // Reach head=3, count=4, then flush with alloc and retire present
    drive(2, 0, 1'b0); tick();
    drive(2, 0, 1'b0); tick();
    drive(1, 0, 1'b0); tick();
    drive(0, 2, 1'b0); tick();
    drive(0, 1, 1'b0); tick();
    state("pre_flush", 3, 7, 4);
    drive(2, 1, 1'b1);
    #1;
    alloc_chk("flush", 0, 0);
    tick();
    state("flush", 3, 3, 0);

`ifdef ROB_ROLLBACK_EN
    // Reach head=1, tail=6, count=5
    for (int i = 0; i < 4; i++) begin
      drive(2, 0, 1'b0); tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 2, 1'b0); tick();
    end
    drive(2, 0, 1'b0); tick();
    drive(1, 0, 1'b0); tick();
    state("pre_rb", 1, 6, 5);
    drive(2, 1, 1'b0);
    bus.rollback_i      = 1'b1;
    bus.rollback_tail_i = 3'd3;
    #1;
    check("rb.ok", 32'(bus.alloc_ok_o), 32'd0);
    tick();
    state("rb", 2, 3, 1);
    drive(0, 0, 1'b0);
    bus.rollback_i      = 1'b1;
    bus.rollback_tail_i = 3'd3;
    tick();
    state("rb_noop", 2, 3, 1);
`endif

    drive(0, 0, 1'b0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so a broken DUT cannot hang the run.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
